// File: rtl/hazard_ctrl.sv
// Purpose: decode-stage hazard controller; scoreboards long-latency destinations and sequences the shared MDU.
// Latency: stall_id/issue/mdu_start/mdu_kill are combinational; scoreboard, FSM and watchdog update on the next clk edge.
// Backpressure: decode is held with stall_id on RAW/WAW/structural hazards; flush_all overrides and drops the instruction.
//
// Ports:
//   clk, reset             - core clock, synchronous active-high reset
//   id_*                   - decoded instruction currently in ID (sources, destination, class)
//   res_valid, res_rd      - long-latency result reaching the forwarding path this cycle
//   mdu_done               - MDU finished its current op
//   flush_all              - whole-pipeline flush (exception/trap)
//   stall_id, issue        - hold decode / advance ID->EX
//   mdu_start, mdu_kill    - MDU start pulse / abort
//   mdu_timeout            - sticky watchdog flag
//   busy_mask              - scoreboard contents, debug view
//
// Build option: define HAZARD_RES_BYPASS_EN to let a result arriving this cycle
// clear the hazard immediately (dependent instruction issues in the res_valid cycle).
// Without it, the dependent instruction issues the cycle after res_valid.

module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        id_is_mdu,
  input  logic        res_valid,
  input  logic [4:0]  res_rd,
  input  logic        mdu_done,
  input  logic        flush_all,
  output logic        stall_id,
  output logic        issue,
  output logic        mdu_start,
  output logic        mdu_kill,
  output logic        mdu_timeout,
  output logic [31:0] busy_mask
);

  // MDU sequencer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Counter value at which the watchdog fires (mdu_cnt counts BUSY cycles from 0)
  localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);

  logic [31:0] sb;
  logic [31:0] sb_next;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_vec;
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [7:0]  mdu_cnt;
  logic [7:0]  cnt_next;
  logic        raw_haz;
  logic        waw_haz;
  logic        str_haz;
  logic        sb_set_en;
  logic        timeout_hit;

  // ------------------------------------------------------------------
  // Scoreboard view used for hazard detection
  // ------------------------------------------------------------------
  always_comb begin
    clr_mask = '0;
    if (res_valid) begin
      clr_mask = 32'b1 << res_rd;
    end
  end

`ifdef HAZARD_RES_BYPASS_EN
  // A result arriving this cycle is forwarded, so it no longer blocks.
  assign busy_vec = sb & ~clr_mask;
`else
  // The arriving result is only usable from the register file/WB path next cycle.
  assign busy_vec = sb;
`endif

  // ------------------------------------------------------------------
  // Hazard detection and issue
  // ------------------------------------------------------------------
  always_comb begin
    raw_haz = (id_rs1_used & busy_vec[id_rs1]) | (id_rs2_used & busy_vec[id_rs2]);
    waw_haz = id_regwrite & busy_vec[id_rd];
    str_haz = id_is_mdu & (state != ST_IDLE);
  end

  assign stall_id  = id_valid & ~flush_all & (raw_haz | waw_haz | str_haz);
  assign issue     = id_valid & ~flush_all & ~stall_id;
  // issue already excludes the structural hazard, so the FSM is IDLE here
  assign mdu_start = issue & id_is_mdu & (state == ST_IDLE);
  assign mdu_kill  = flush_all & (state == ST_BUSY);

  // ------------------------------------------------------------------
  // Scoreboard next state: clear first so a same-index set wins
  // ------------------------------------------------------------------
  assign sb_set_en = issue & id_regwrite & (id_is_load | id_is_mdu) & (id_rd != 5'd0);

  always_comb begin
    set_mask = '0;
    if (sb_set_en) begin
      set_mask = 32'b1 << id_rd;
    end
  end

  always_comb begin
    sb_next    = (sb & ~clr_mask) | set_mask;
    sb_next[0] = 1'b0;
  end

  // ------------------------------------------------------------------
  // MDU FSM and watchdog counter
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = mdu_cnt;
    case (state)
      ST_IDLE: begin
        // mdu_done while IDLE is a stale/unrelated pulse and is ignored
        if (mdu_start) begin
          state_next = ST_BUSY;
          cnt_next   = '0;
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          state_next = ST_IDLE;
        end
        if (mdu_cnt != 8'hFF) begin
          cnt_next = mdu_cnt + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign timeout_hit = (state == ST_BUSY) && (mdu_cnt == TO_LAST);

  // ------------------------------------------------------------------
  // State registers: reset beats flush beats normal update
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sb          <= '0;
      state       <= ST_IDLE;
      mdu_cnt     <= '0;
      mdu_timeout <= 1'b0;
    end else if (flush_all) begin
      sb          <= '0;
      state       <= ST_IDLE;
      mdu_cnt     <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      sb      <= sb_next;
      state   <= state_next;
      mdu_cnt <= cnt_next;
      if (timeout_hit) begin
        mdu_timeout <= 1'b1;
      end
    end
  end

  assign busy_mask = sb;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl (load-use, MDU sequencing, WAW, set/clear, watchdog, reset).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled 2 time units after the edge.
// Backpressure: n/a (bench drives every cycle explicitly).

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic        id_is_mdu;
  logic        res_valid;
  logic [4:0]  res_rd;
  logic        mdu_done;
  logic        flush_all;
  logic        stall_id;
  logic        issue;
  logic        mdu_start;
  logic        mdu_kill;
  logic        mdu_timeout;
  logic [31:0] busy_mask;

  int total  = 0;
  int passed = 0;

  hazard_ctrl #(.MDU_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .id_is_mdu   (id_is_mdu),
    .res_valid   (res_valid),
    .res_rd      (res_rd),
    .mdu_done    (mdu_done),
    .flush_all   (flush_all),
    .stall_id    (stall_id),
    .issue       (issue),
    .mdu_start   (mdu_start),
    .mdu_kill    (mdu_kill),
    .mdu_timeout (mdu_timeout),
    .busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Move to the next cycle: inputs may be changed right after this returns.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    id_valid    = 1'b0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd       = 5'd0;
    id_regwrite = 1'b0;
    id_is_load  = 1'b0;
    id_is_mdu   = 1'b0;
    res_valid   = 1'b0;
    res_rd      = 5'd0;
    mdu_done    = 1'b0;
    flush_all   = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                        input logic rs2u, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic mdu);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs1_used = rs1u;
    id_rs2      = rs2;
    id_rs2_used = rs2u;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_is_mdu   = mdu;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    cyc();

    // ---------------- reset state ----------------
    do_reset();
    settle();
    chk("rst_stall",   {31'd0, stall_id},    32'd0);
    chk("rst_issue",   {31'd0, issue},       32'd0);
    chk("rst_start",   {31'd0, mdu_start},   32'd0);
    chk("rst_kill",    {31'd0, mdu_kill},    32'd0);
    chk("rst_timeout", {31'd0, mdu_timeout}, 32'd0);
    chk("rst_mask",    busy_mask,            32'd0);

    // ---------------- load-use: lw x5 ; add x6,x5,x1 ----------------
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);     // cycle 0
    settle();
    chk("lu_c0_issue", {31'd0, issue}, 32'd1);
    cyc();                                                       // cycle 1
    set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("lu_c1_mask",  busy_mask, 32'h0000_0020);
    chk("lu_c1_stall", {31'd0, stall_id}, 32'd1);
    cyc();                                                       // cycle 2
    settle();
    chk("lu_c2_stall", {31'd0, stall_id}, 32'd1);
    cyc();                                                       // cycle 3: result arrives
    res_valid = 1'b1;
    res_rd    = 5'd5;
    settle();
`ifdef HAZARD_RES_BYPASS_EN
    chk("lu_c3_issue", {31'd0, issue}, 32'd1);
    cyc();
    idle_inputs();
`else
    chk("lu_c3_stall", {31'd0, stall_id}, 32'd1);
    cyc();                                                       // cycle 4
    res_valid = 1'b0;
    settle();
    chk("lu_c4_mask",  busy_mask, 32'd0);
    chk("lu_c4_issue", {31'd0, issue}, 32'd1);
    cyc();
    idle_inputs();
`endif

    // ---------------- MDU back-to-back: mul x7 ; div x8 ----------------
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);     // cycle 0
    settle();
    chk("mdu_c0_issue", {31'd0, issue},     32'd1);
    chk("mdu_c0_start", {31'd0, mdu_start}, 32'd1);
    cyc();                                                       // cycle 1
    set_id(5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    settle();
    chk("mdu_c1_mask",  busy_mask, 32'h0000_0080);
    chk("mdu_c1_stall", {31'd0, stall_id},  32'd1);
    chk("mdu_c1_start", {31'd0, mdu_start}, 32'd0);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      settle();
      chk("mdu_wait_stall", {31'd0, stall_id}, 32'd1);
    end
    cyc();                                                       // cycle 5: done + result
    mdu_done  = 1'b1;
    res_valid = 1'b1;
    res_rd    = 5'd7;
    settle();
    chk("mdu_c5_stall", {31'd0, stall_id},  32'd1);
    chk("mdu_c5_start", {31'd0, mdu_start}, 32'd0);
    cyc();                                                       // cycle 6
    mdu_done  = 1'b0;
    res_valid = 1'b0;
    settle();
    chk("mdu_c6_mask",  busy_mask, 32'd0);
    chk("mdu_c6_issue", {31'd0, issue},     32'd1);
    chk("mdu_c6_start", {31'd0, mdu_start}, 32'd1);
    cyc();                                                       // cycle 7
    idle_inputs();
    settle();
    chk("mdu_c7_mask",  busy_mask, 32'h0000_0100);
    chk("mdu_c7_start", {31'd0, mdu_start}, 32'd0);

    // ---------------- WAW: lw x9 ; addi x9,x0,1 ----------------
    do_reset();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    settle();
    chk("waw_c0_issue", {31'd0, issue}, 32'd1);
    cyc();
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("waw_c1_stall", {31'd0, stall_id}, 32'd1);
    cyc();
    settle();
    chk("waw_c2_stall", {31'd0, stall_id}, 32'd1);
    cyc();
    res_valid = 1'b1;
    res_rd    = 5'd9;
    settle();
`ifdef HAZARD_RES_BYPASS_EN
    chk("waw_c3_issue", {31'd0, issue}, 32'd1);
    cyc();
    res_valid = 1'b0;
`else
    chk("waw_c3_stall", {31'd0, stall_id}, 32'd1);
    cyc();
    res_valid = 1'b0;
    settle();
    chk("waw_c4_issue", {31'd0, issue}, 32'd1);
    cyc();
`endif
    // load to x0 never sets the scoreboard
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("x0_issue", {31'd0, issue}, 32'd1);
    cyc();
    // write to x0 reading x0 never stalls
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("x0_mask",  busy_mask, 32'd0);
    chk("x0_stall", {31'd0, stall_id}, 32'd0);
    cyc();
    idle_inputs();

    // ---------------- same-cycle set/clear on x10 ----------------
    do_reset();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    res_valid = 1'b1;
    res_rd    = 5'd10;
    settle();
    chk("sc_issue", {31'd0, issue}, 32'd1);
    cyc();
    idle_inputs();
    settle();
    chk("sc_mask", busy_mask, 32'h0000_0400);

    // ---------------- watchdog with MDU_TIMEOUT=4 ----------------
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    settle();
    chk("wd_start", {31'd0, mdu_start}, 32'd1);
    cyc();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("wd_busy_no_to", {31'd0, mdu_timeout}, 32'd0);
      cyc();
    end
    settle();
    chk("wd_to_rise", {31'd0, mdu_timeout}, 32'd1);
    cyc();
    settle();
    chk("wd_to_hold", {31'd0, mdu_timeout}, 32'd1);
    cyc();
    // flush with an MDU op waiting in ID
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    flush_all = 1'b1;
    settle();
    chk("fl_kill",  {31'd0, mdu_kill}, 32'd1);
    chk("fl_issue", {31'd0, issue},    32'd0);
    chk("fl_stall", {31'd0, stall_id}, 32'd0);
    cyc();
    flush_all = 1'b0;
    settle();
    chk("fl_mask",    busy_mask, 32'd0);
    chk("fl_timeout", {31'd0, mdu_timeout}, 32'd0);
    chk("fl_kill_0",  {31'd0, mdu_kill},    32'd0);
    chk("fl_idle_start", {31'd0, mdu_start}, 32'd1);
    cyc();
    idle_inputs();

    // ---------------- reset while BUSY with three scoreboard bits ----------------
    do_reset();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);     // lw x1
    cyc();
    set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);     // lw x2
    cyc();
    set_id(5'd4, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);     // mul x3
    settle();
    chk("rb_start", {31'd0, mdu_start}, 32'd1);
    cyc();
    idle_inputs();
    reset    = 1'b1;
    mdu_done = 1'b1;
    settle();
    chk("rb_mask_pre", busy_mask, 32'h0000_000E);
    cyc();
    reset    = 1'b0;
    mdu_done = 1'b0;
    settle();
    chk("rb_mask",    busy_mask, 32'd0);
    chk("rb_timeout", {31'd0, mdu_timeout}, 32'd0);
    chk("rb_no_start", {31'd0, mdu_start},  32'd0);
    cyc();
    set_id(5'd4, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    settle();
    chk("rb_new_start", {31'd0, mdu_start}, 32'd1);
    cyc();
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller and issue scheduler sitting between the decode and execute stages of the pipelined core. It keeps a 32-entry scoreboard of destination registers whose results are not yet reachable by the forwarding network (loads in flight, multi-cycle multiply/divide ops). It stalls decode on RAW/WAW hazards against those registers and sequences the single shared multiply/divide unit (MDU) with a busy FSM and a watchdog counter.

## Interface
- `MDU_TIMEOUT`, default 64: cycles an MDU op may stay busy before `mdu_timeout` asserts.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1`, `id_rs2` in 5 each: source register addresses.
- `id_rs1_used`, `id_rs2_used` in 1 each: the corresponding source is actually read.
- `id_rd` in 5: destination register.
- `id_regwrite` in 1: instruction writes `id_rd`.
- `id_is_load` in 1: instruction is a load.
- `id_is_mdu` in 1: instruction is a MUL/DIV/REM op.
- `res_valid` in 1: a long-latency result (load data or MDU result) reaches the forwarding path this cycle.
- `res_rd` in 5: register of that result.
- `mdu_done` in 1: MDU finished its current op.
- `flush_all` in 1: exception/trap flush of the whole pipeline.
- `stall_id` out 1: hold the PC and the IF/ID register; insert a bubble into EX.
- `issue` out 1: instruction advances ID→EX this cycle.
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_kill` out 1: abort the MDU op.
- `mdu_timeout` out 1: sticky watchdog flag.
- `busy_mask` out 32: scoreboard contents, for debug.

## Operation
- Scoreboard `sb[31:0]`:
  - On `issue`, set `sb[id_rd]` if `id_regwrite & (id_is_load | id_is_mdu) & id_rd != 0`.
  - On `res_valid`, clear `sb[res_rd]`.
  - If set and clear hit the same index in the same cycle, set wins.
  - `sb[0]` is always 0.
- `busy(r)` = `sb[r]`, excluding a register being cleared this cycle (see Configuration).
- RAW hazard: `id_rs1_used & busy(id_rs1)`, or the same check on rs2.
- WAW hazard: `id_regwrite & busy(id_rd)`.
- Structural hazard: `id_is_mdu` while the MDU FSM is not IDLE.
- `stall_id` = `id_valid & ~flush_all & (RAW | WAW | structural)`.
- `issue` = `id_valid & ~flush_all & ~stall_id`.
- MDU FSM:
  - IDLE: `issue & id_is_mdu` → pulse `mdu_start` and go to BUSY.
  - BUSY: `mdu_done` → IDLE. `mdu_done` while IDLE is ignored.
- Watchdog counter `mdu_cnt` (8-bit, saturating):
  - Cleared on entry to BUSY; increments each BUSY cycle.
  - When `mdu_cnt == MDU_TIMEOUT - 1` in BUSY, set `mdu_timeout`. It stays set until `reset` or `flush_all`.
- `flush_all`:
  - Next cycle: `sb` = 0, FSM = IDLE, counter = 0, `mdu_timeout` = 0.
  - Same cycle: `mdu_kill` = 1 if the FSM is BUSY; `issue` = 0; `stall_id` = 0.

## Timing
- `stall_id`, `issue`, `mdu_start` and `mdu_kill` are combinational from current inputs and state. Scoreboard, FSM, counter and `mdu_timeout` update on the rising edge of `clk`.
- Reset (sync): `sb` = 0, FSM = IDLE, `mdu_cnt` = 0, `mdu_timeout` = 0, `busy_mask` = 0. With `id_valid` = 0, all combinational outputs are 0.
- Load-use with bypass:
  - Load issues in cycle N; `sb[rd]` is visible from N+1.
  - A dependent instruction in ID stalls until the cycle `res_valid` for `rd` arrives.
  - It issues in that same cycle.
- Back-to-back MDU ops: the second stalls until the cycle after `mdu_done`. Minimum spacing is MDU latency + 1.
- `reset` asserted mid-operation overrides everything, including a pending `mdu_done`.

## Configuration
- `HAZARD_RES_BYPASS_EN` defined: `busy(r)` = `sb[r] & ~(res_valid & res_rd == r)`. A result arriving this cycle is forwarded and clears the hazard immediately.
- Not defined: `busy(r)` = `sb[r]`. The dependent instruction issues one cycle after `res_valid`; the forwarding unit then sources the value from the register file/WB path.

## Test plan
- Reset, then a load `x5` issues, then `add x6,x5,x1` sits in ID with `res_valid` at cycle 3:
  - With bypass: `stall_id` = 1 in cycles 1–2; `issue` in cycle 3.
  - Without bypass: `issue` in cycle 4.
- `mul x7` issues, then `div x8` in ID; `mdu_done` arrives 5 cycles later:
  - `mdu_start` pulses once at issue.
  - `div` stalls until the cycle after `mdu_done`, then `mdu_start` pulses again.
- WAW: load `x9` in flight, then `addi x9,x0,1` in ID → `stall_id` = 1 until `x9` clears. `rd = x0` ops never set `sb` and never stall.
- Same-cycle set/clear: issue a load to `x10` while `res_valid` with `res_rd = 10` → `busy_mask[10]` = 1 next cycle.
- `MDU_TIMEOUT` = 4, MDU op never signals `mdu_done`:
  - `mdu_timeout` rises after 4 BUSY cycles and stays high.
  - `flush_all` then gives `mdu_kill` = 1 that cycle, and next cycle `busy_mask` = 0, FSM IDLE, `mdu_timeout` = 0.
- `reset` asserted while BUSY with 3 scoreboard bits set → all state cleared next cycle; no `mdu_start` until a new MDU issue.
